uart_periph: RTL and testbench

//  Memory-mapped 8N1 UART peripheral on the CPU peripheral bus, downstream of the execute stage.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_rx_fsm.sv | 120 ++++++++++++
 rtl/uart_periph.sv | 212 +++++++++++++++++++++
 tb/tb_uart_periph.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register offsets, CON bit
// positions and the TX/RX state encodings.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] ADDR_TXD = 8'h18;
  localparam logic [7:0] ADDR_RXD = 8'h1C;
  localparam logic [7:0] ADDR_CON = 8'h20;

  localparam int CON_RX_INT_EN    = 0;
  localparam int CON_TX_INT_EN    = 1;
  localparam int CON_RX_VALID     = 2;
  localparam int CON_TX_DONE      = 3;
  localparam int CON_TX_BUSY      = 4;
  localparam int CON_RX_OVERRUN   = 5;
  localparam int CON_RX_FRAME_ERR = 6;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Zero-extend a byte register onto the 32-bit load bus.
  function automatic logic [31:0] zext8(input logic [DATA_W-1:0] v);
    return {24'h0, v};
  endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive path: 2-FF synchroniser, start-bit qualification, mid-bit
// sampling of 8 data bits plus stop, and one-cycle result pulses.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_ok,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic              sync1;
  logic              sync2;
  logic              rx_prev;
  rx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shreg;

  assign rx_byte = shreg;

  // Bring the asynchronous line into the clk domain and keep one more
  // delayed copy for falling-edge detection; idle line level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  // Frame state machine: qualify the start bit at half a bit time, then
  // sample each following bit one full bit time later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !sync2) begin
            state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (sync2) begin
              // Line went back high before mid start bit: treat as a glitch.
              state <= RX_IDLE;
            end else begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[DATA_W-1:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (sync2) begin
              byte_ok <= 1'b1;
              state   <= RX_IDLE;
            end else begin
              // A low stop bit must not be mistaken for the next start bit,
              // so wait for the line to recover before re-arming.
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          cnt <= '0;
          if (sync2) begin
            state <= RX_IDLE;
          end
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON register file, transmit state machine,
// receive path instance and registered level interrupt.
module uart_periph
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        um_wr,
  input  logic        um_rd,
  output logic [31:0] um_data,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [7:0]        offset;
  logic              txd_wr;
  logic              con_wr;
  logic              rxd_rd;
  logic              con_rd;

  tx_state_t         tx_state;
  logic [CNT_W-1:0]  tx_cnt;
  logic [2:0]        tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_busy;
  logic              tx_finish;

  logic              rx_int_en;
  logic              tx_int_en;
  logic              rx_valid;
  logic              tx_done;
  logic              rx_overrun;
  logic              rx_frame_err;
  logic [DATA_W-1:0] rxd;
  logic [7:0]        con_val;

  logic [DATA_W-1:0] rx_byte;
  logic              byte_ok;
  logic              frame_err;

  // Upper address and data bits are intentionally ignored by this block.
  logic unused_bits;
  assign unused_bits = ^{addr[31:8], wdata[31:8]};

  assign offset    = addr[7:0];
  assign txd_wr    = um_wr && (offset == ADDR_TXD);
  assign con_wr    = um_wr && (offset == ADDR_CON);
  assign rxd_rd    = um_rd && (offset == ADDR_RXD);
  assign con_rd    = um_rd && (offset == ADDR_CON);

  assign tx_busy   = (tx_state != TX_IDLE);
  assign tx_finish = (tx_state == TX_STOP) && (tx_cnt == CNT_LAST);

  uart_rx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (uart_rx),
    .rx_byte  (rx_byte),
    .byte_ok  (byte_ok),
    .frame_err(frame_err)
  );

  // Transmit state machine; uart_tx is registered so it is glitch-free and
  // returns high the moment reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_cnt  <= '0;
          uart_tx <= 1'b1;
          if (txd_wr) begin
            tx_shift <= wdata[DATA_W-1:0];
            tx_bit   <= '0;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[DATA_W-1:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

  // Control/status register file; every set event has priority over the
  // read-side clear that may land on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_int_en    <= 1'b0;
      tx_int_en    <= 1'b0;
      rx_valid     <= 1'b0;
      tx_done      <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rxd          <= '0;
    end else begin
      if (con_wr) begin
        rx_int_en <= wdata[CON_RX_INT_EN];
        tx_int_en <= wdata[CON_TX_INT_EN];
      end

      if (tx_finish) begin
        tx_done <= 1'b1;
      end else if (con_rd) begin
        tx_done <= 1'b0;
      end

      if (byte_ok) begin
        rxd      <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end

      // A byte arriving as the old one is being read is not an overrun.
      if (byte_ok && rx_valid && !rxd_rd) begin
        rx_overrun <= 1'b1;
      end else if (con_rd) begin
        rx_overrun <= 1'b0;
      end

      if (frame_err) begin
        rx_frame_err <= 1'b1;
      end else if (con_rd) begin
        rx_frame_err <= 1'b0;
      end
    end
  end

  // Level interrupt, registered one cycle behind its status sources.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (rx_int_en & rx_valid) | (tx_int_en & tx_done);
    end
  end

  // Assemble the CON view from the individual status bits.
  always_comb begin
    con_val                   = '0;
    con_val[CON_RX_INT_EN]    = rx_int_en;
    con_val[CON_TX_INT_EN]    = tx_int_en;
    con_val[CON_RX_VALID]     = rx_valid;
    con_val[CON_TX_DONE]      = tx_done;
    con_val[CON_TX_BUSY]      = tx_busy;
    con_val[CON_RX_OVERRUN]   = rx_overrun;
    con_val[CON_RX_FRAME_ERR] = rx_frame_err;
  end

  // Zero-latency load data; the bus sees zero unless a load is in progress.
  always_comb begin
    um_data = '0;
    if (um_rd) begin
      case (offset)
        ADDR_RXD: um_data = zext8(rxd);
        ADDR_CON: um_data = zext8(con_val);
        default:  um_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph with a short bit time.
module tb_uart_periph;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        um_wr = 1'b0;
  logic        um_rd = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] um_data;
  logic        uart_tx;
  logic        irq;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [7:0] tx_q[$];
  bit         tx_mon_en = 1'b1;
  bit         hold_rd = 1'b0;

  uart_periph #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .um_wr  (um_wr),
    .um_rd  (um_rd),
    .um_data(um_data),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read scoreboard: each load pushes its expectation, popped when um_rd is seen.
  always @(negedge clk) begin
    rd_exp_t e;
    if (um_rd && !hold_rd) begin
      if (rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", um_data);
      end else begin
        e = rd_q.pop_front();
        check(e.name, um_data, e.exp);
      end
    end
  end

  // Serial scoreboard: decode each frame on uart_tx at mid-bit and match it
  // against the bytes queued by the stimulus.
  always begin
    logic [7:0] got;
    logic       start_ok;
    logic       stop_ok;
    @(negedge clk);
    if (tx_mon_en && reset && !uart_tx) begin
      repeat (CPB / 2 - 1) @(negedge clk);
      start_ok = !uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        got[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      stop_ok = uart_tx;
      check("tx_start_bit", {31'b0, start_ok}, 32'd1);
      check("tx_stop_bit", {31'b0, stop_ok}, 32'd1);
      if (tx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tx_unexpected_frame: got 0x%0h expected no frame", got);
      end else begin
        check("tx_byte", {24'h0, got}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    addr  = {24'h0, a};
    wdata = {24'h0, d};
    um_wr = 1'b1;
    @(posedge clk);
    #1;
    um_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.exp  = exp;
    @(posedge clk);
    #1;
    addr = {24'h0, a};
    rd_q.push_back(e);
    um_rd = 1'b1;
    @(posedge clk);
    #1;
    um_rd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int lows;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b1;
    rd(ADDR_CON, 32'h00, "rst_con");
    rd(ADDR_RXD, 32'h00, "rst_rxd");
    rd(ADDR_TXD, 32'h00, "txd_reads_zero");
    rd(8'h24, 32'h00, "unmapped_read");

    // Single byte: busy for exactly 160 cycles, then sticky done.
    tx_q.push_back(8'h55);
    wr(ADDR_TXD, 8'h55);
    repeat (158) @(posedge clk);
    rd(ADDR_CON, 32'h10, "tx_busy_last_cycle");
    rd(ADDR_CON, 32'h08, "tx_done_set");
    rd(ADDR_CON, 32'h00, "tx_done_cleared");
    check("irq_disabled", {31'b0, irq}, 32'd0);

    // Write while busy is dropped.
    tx_q.push_back(8'hA3);
    wr(ADDR_TXD, 8'hA3);
    repeat (3) @(posedge clk);
    wr(ADDR_TXD, 8'hFF);
    repeat (170) @(posedge clk);
    rd(ADDR_CON, 32'h08, "tx_done_once");
    rd(ADDR_CON, 32'h00, "tx_done_clr2");
    repeat (200) @(posedge clk);
    rd(ADDR_CON, 32'h00, "no_second_frame");

    // Receive one byte.
    send_rx(8'h3C, 1'b1);
    rd(ADDR_CON, 32'h04, "rx_valid");
    rd(ADDR_RXD, 32'h3C, "rxd_3c");
    rd(ADDR_CON, 32'h00, "rx_valid_clr");

    // Overrun.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(ADDR_RXD, 32'h22, "rx_overwrite");
    rd(ADDR_CON, 32'h20, "rx_overrun");
    rd(ADDR_CON, 32'h00, "rx_overrun_clr");

    // Framing error and glitch.
    send_rx(8'h7E, 1'b0);
    rd(ADDR_CON, 32'h40, "rx_frame_err");
    rd(ADDR_CON, 32'h00, "rx_frame_err_clr");
    rd(ADDR_RXD, 32'h22, "rxd_kept");
    @(posedge clk);
    #1;
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    rd(ADDR_CON, 32'h00, "glitch_ignored");

    // Interrupts.
    wr(ADDR_CON, 8'h03);
    @(negedge clk);
    check("irq_idle", {31'b0, irq}, 32'd0);
    @(posedge clk);
    #1;
    addr    = {24'h0, ADDR_CON};
    hold_rd = 1'b1;
    um_rd   = 1'b1;
    seen    = 1'b0;
    fork
      send_rx(8'h5A, 1'b1);
      begin
        for (int i = 0; i < CPB * 14 && !seen; i++) begin
          @(negedge clk);
          if (um_data[CON_RX_VALID]) begin
            seen = 1'b1;
            check("irq_before_reg", {31'b0, irq}, 32'd0);
            @(negedge clk);
            check("irq_rx", {31'b0, irq}, 32'd1);
          end
        end
      end
    join
    check("rx_valid_seen", {31'b0, seen}, 32'd1);
    @(posedge clk);
    #1;
    um_rd   = 1'b0;
    hold_rd = 1'b0;
    rd(ADDR_RXD, 32'h5A, "rxd_5a");
    repeat (2) @(negedge clk);
    check("irq_rx_clr", {31'b0, irq}, 32'd0);

    tx_q.push_back(8'h81);
    wr(ADDR_TXD, 8'h81);
    repeat (165) @(posedge clk);
    @(negedge clk);
    check("irq_tx", {31'b0, irq}, 32'd1);
    rd(ADDR_CON, 32'h0B, "con_tx_irq");
    repeat (2) @(negedge clk);
    check("irq_tx_clr", {31'b0, irq}, 32'd0);

    // Reset in the middle of a frame.
    tx_mon_en = 1'b0;
    wr(ADDR_TXD, 8'hF0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("tx_mid_frame", {31'b0, uart_tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("rst_tx_high", {31'b0, uart_tx}, 32'd1);
    check("rst_irq_low", {31'b0, irq}, 32'd0);
    rd(ADDR_CON, 32'h00, "rst_mid_con");
    rd(ADDR_RXD, 32'h00, "rst_mid_rxd");
    @(posedge clk);
    #1;
    reset = 1'b1;
    tx_mon_en = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!uart_tx) lows++;
    end
    check("tx_idle_after_rst", 32'(lows), 32'd0);
    rd(ADDR_CON, 32'h00, "con_after_rst");

    repeat (2) @(negedge clk);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
